// File: rtl/q_sys_csr_slave.sv
// Avalon-MM responder for the system control/status register bank.
// Fixed-latency pipelined reads, byte-enabled writes, waitrequest only during post-reset init.
module q_sys_csr_slave #(
    parameter int          READ_LATENCY = 2,
    parameter int          INIT_CYCLES  = 8,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter logic [31:0] BAD_DATA     = 32'hDEAD_BEEF
) (
    input  logic        clk_clk,
    input  logic        clk_reset_reset,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic [3:0]  slave_byteenable,
    output logic [31:0] slave_readdata,
    output logic        slave_waitrequest,
    output logic        slave_readdatavalid,
    output logic [31:0] ctrl_out,
    input  logic [31:0] status_in
);

    localparam logic [3:0] IDX_VERSION = 4'd0;
    localparam logic [3:0] IDX_SCRATCH = 4'd1;
    localparam logic [3:0] IDX_CONTROL = 4'd2;
    localparam logic [3:0] IDX_STATUS  = 4'd3;
    localparam logic [3:0] IDX_FREECNT = 4'd4;
    localparam logic [3:0] IDX_WRCOUNT = 4'd5;
    localparam logic [3:0] IDX_ERR     = 4'd6;
    localparam logic [3:0] IDX_ERRADDR = 4'd7;

    logic [7:0]  init_cnt;
    logic        rd_acc, wr_acc, collide, mapped, unmapped_acc, map_wr;
    logic [3:0]  idx;
    logic [31:0] scratch, control, freecnt, wrcount, erraddr;
    logic [31:0] gp [8];
    logic [1:0]  err, err_next;
    logic [31:0] rd_mux;
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [31:0] pipe_data [READ_LATENCY];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int n = 0; n < 4; n++)
            if (be[n]) res[8*n +: 8] = data[8*n +: 8];
        return res;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_clk or posedge clk_reset_reset) begin
        if (clk_reset_reset)
            init_cnt <= 8'(INIT_CYCLES);
        else if (init_cnt != 8'd0)
            init_cnt <= init_cnt - 8'd1;
    end

    assign slave_waitrequest = (init_cnt != 8'd0);
    assign rd_acc       = !slave_waitrequest && slave_read && !slave_write;
    assign wr_acc       = !slave_waitrequest && slave_write && !slave_read;
    assign collide      = !slave_waitrequest && slave_read && slave_write;
    assign mapped       = (slave_address[31:6] == 26'd0) && (slave_address[1:0] == 2'd0);
    assign idx          = slave_address[5:2];
    assign unmapped_acc = (rd_acc || wr_acc) && !mapped;
    assign map_wr       = wr_acc && mapped;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        err_next = err;
        if (map_wr && idx == IDX_ERR && slave_byteenable[0])
            err_next = err & ~slave_writedata[1:0];
        // New errors are applied after the clear so they win on the same edge.
        if (collide)      err_next[0] = 1'b1;
        if (unmapped_acc) err_next[1] = 1'b1;
    end

    // NOTE: the GP bank is small and must read zero after reset, so it is reset like plain flops.
    always_ff @(posedge clk_clk or posedge clk_reset_reset) begin
        if (clk_reset_reset) begin
            scratch <= '0;
            control <= '0;
            freecnt <= '0;
            wrcount <= '0;
            err     <= '0;
            erraddr <= '0;
            for (int i = 0; i < 8; i++) gp[i] <= '0;
        end else begin
            err     <= err_next;
            freecnt <= freecnt + 32'd1;
            if (unmapped_acc) erraddr <= slave_address;
            if (map_wr) begin
                if (wrcount != '1) wrcount <= wrcount + 32'd1;
                if (idx[3])
                    gp[idx[2:0]] <= merge(gp[idx[2:0]], slave_writedata, slave_byteenable);
                else if (idx == IDX_SCRATCH)
                    scratch <= merge(scratch, slave_writedata, slave_byteenable);
                else if (idx == IDX_CONTROL)
                    control <= merge(control, slave_writedata, slave_byteenable);
                else if (idx == IDX_FREECNT)
                    freecnt <= '0;
            end
        end
    end

    always_comb begin
        rd_mux = BAD_DATA;
        if (mapped) begin
            if (idx[3]) rd_mux = gp[idx[2:0]];
            else begin
                case (idx)
                    IDX_VERSION: rd_mux = VERSION;
                    IDX_SCRATCH: rd_mux = scratch;
                    IDX_CONTROL: rd_mux = control;
                    IDX_STATUS:  rd_mux = status_in;
                    IDX_FREECNT: rd_mux = freecnt;
                    IDX_WRCOUNT: rd_mux = wrcount;
                    IDX_ERR:     rd_mux = {30'd0, err};
                    IDX_ERRADDR: rd_mux = erraddr;
                    default:     rd_mux = BAD_DATA;
                endcase
            end
        end
    end

    // Data stages only load behind a valid, so the last stage holds readdata between strobes.
    always_ff @(posedge clk_clk or posedge clk_reset_reset) begin
        if (clk_reset_reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) pipe_data[0] <= rd_mux;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign slave_readdatavalid = pipe_vld[READ_LATENCY-1];
    assign slave_readdata      = pipe_data[READ_LATENCY-1];
    assign ctrl_out            = control;

endmodule

// File: tb/tb_q_sys_csr_slave.sv
// Self-checking bench for q_sys_csr_slave: read expectations are queued when a read
// is driven and compared (data and latency) when readdatavalid strobes.
module tb_q_sys_csr_slave;

    localparam int          RL      = 2;
    localparam logic [31:0] VER     = 32'h0001_0000;
    localparam logic [31:0] BAD     = 32'hDEAD_BEEF;
    localparam logic [31:0] STATUS  = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr, wdata, rdata, ctrl;
    logic        read, write, waitreq, rdv;
    logic [3:0]  byteen;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    q_sys_csr_slave #(
        .READ_LATENCY(RL), .INIT_CYCLES(8), .VERSION(VER), .BAD_DATA(BAD)
    ) dut (
        .clk_clk            (clk),
        .clk_reset_reset    (rst),
        .slave_address      (addr),
        .slave_read         (read),
        .slave_write        (write),
        .slave_writedata    (wdata),
        .slave_byteenable   (byteen),
        .slave_readdata     (rdata),
        .slave_waitrequest  (waitreq),
        .slave_readdatavalid(rdv),
        .ctrl_out           (ctrl),
        .status_in          (STATUS)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rdv !== 1'b0) begin
            if (sb.size() == 0) begin
                check("rdv_unexpected", {31'd0, rdv}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rdata", rdata, e.data);
                check("latency", cyc - e.cyc, RL);
            end
        end
    end

    task automatic bus(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        read = rd; write = wr; addr = a; wdata = d; byteen = be;
    endtask

    task automatic rd_exp(input logic [31:0] a, input logic [31:0] e);
        bus(1'b1, 1'b0, a, 32'd0, 4'h0);
        sb.push_back('{e, cyc});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus(1'b0, 1'b1, a, d, be);
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    endtask

    task automatic drain();
        int n;
        idle();
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        int n;
        read = 1'b0; write = 1'b0; addr = '0; wdata = '0; byteen = '0;
        repeat (3) @(negedge clk);
        check("rst_waitreq", {31'd0, waitreq}, 32'd1);
        check("rst_rdv", {31'd0, rdv}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ctrl", ctrl, 32'd0);

        // Hold a read through init: it must be accepted exactly once after waitrequest drops.
        read = 1'b1; addr = 32'h0; rst = 1'b0;
        n = 0;
        while (waitreq && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("init_cycles", n, 8);
        sb.push_back('{VER, cyc});
        idle();
        drain();

        wr(32'h4, 32'h1234_5678, 4'b1111);
        wr(32'h4, 32'hAABB_CCDD, 4'b0101);
        rd_exp(32'h4, 32'h12BB_56DD);
        rd_exp(32'h14, 32'd2);
        drain();

        rd_exp(32'h8, 32'd0);
        rd_exp(32'h4, 32'h12BB_56DD);
        rd_exp(32'h0, VER);
        rd_exp(32'h8, 32'd0);
        drain();

        wr(32'h8, 32'hA5A5_00FF, 4'b1111);
        idle();
        check("ctrl_full", ctrl, 32'hA5A5_00FF);
        wr(32'h8, 32'h0000_3300, 4'b0010);
        idle();
        check("ctrl_lane1", ctrl, 32'hA5A5_33FF);
        rd_exp(32'h8, 32'hA5A5_33FF);
        rd_exp(32'hC, STATUS);
        drain();

        rd_exp(32'h40, BAD);
        wr(32'h3E, 32'hFFFF_FFFF, 4'b1111);
        rd_exp(32'h18, 32'h2);
        rd_exp(32'h1C, 32'h3E);
        wr(32'h18, 32'h2, 4'b1111);
        rd_exp(32'h18, 32'h0);
        drain();

        bus(1'b1, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'b1111);
        rd_exp(32'h4, 32'h12BB_56DD);
        rd_exp(32'h18, 32'h1);
        drain();

        wr(32'h20, 32'h1111_1111, 4'b1111);
        wr(32'h3C, 32'h2222_2222, 4'b1111);
        rd_exp(32'h20, 32'h1111_1111);
        rd_exp(32'h3C, 32'h2222_2222);
        drain();

        // The cleared counter is sampled as 0 on the next edge and 1 on the one after.
        wr(32'h10, 32'h1234_0000, 4'b0000);
        rd_exp(32'h10, 32'd0);
        rd_exp(32'h10, 32'd1);
        rd_exp(32'h14, 32'd8);
        drain();

        bus(1'b1, 1'b0, 32'h4, 32'd0, 4'h0);
        bus(1'b1, 1'b0, 32'h0, 32'd0, 4'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        read = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rdv_in_rst", {31'd0, rdv}, 32'd0);
        end
        check("rst2_waitreq", {31'd0, waitreq}, 32'd1);
        check("rst2_rdata", rdata, 32'd0);
        check("rst2_ctrl", ctrl, 32'd0);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("rdv_after_rst", {31'd0, rdv}, 32'd0);
        end
        check("rst2_waitreq_low", {31'd0, waitreq}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
